// File: rtl/pc_sequencer.sv
// Next-PC selector (boot / mret / irq / branch / sequential) with interrupt context; outputs are same-cycle combinational.
// Tick=0 or stall=1 hold the PC; define PC_IRQ_NEST_EN for a 3-deep nested interrupt context stack.
module pc_sequencer #(
  parameter int unsigned           NrOfBits    = 32,
  parameter logic [NrOfBits-1:0]   ResetVector = '0,
  parameter logic [NrOfBits-1:0]   IrqBase     = NrOfBits'(32'h0000_1000)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic [NrOfBits-1:0] pc_cur,
  input  logic                stall,
  input  logic                br_taken,
  input  logic [NrOfBits-1:0] br_target,
  input  logic [2:0]          irq_req,
  input  logic                mret,
  input  logic                halt_req,
  input  logic                resume,
  output logic [NrOfBits-1:0] pc_next,
  output logic                pc_en,
  output logic                irq_ack,
  output logic [1:0]          irq_id,
  output logic [NrOfBits-1:0] epc,
  output logic                in_service,
  output logic                halted,
  output logic                mret_err
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [NrOfBits-1:0] pc_seq;
  logic [NrOfBits-1:0] ret_addr;
  logic [1:0]          irq_lvl;
  logic                irq_any;
  logic                can_accept;
  logic                ctx_push;
  logic                ctx_pop;

  // Highest-numbered pending request wins.
  always_comb begin
    irq_lvl = 2'd0;
    if (irq_req[2])      irq_lvl = 2'd2;
    else if (irq_req[1]) irq_lvl = 2'd1;
    else                 irq_lvl = 2'd0;
  end

  assign irq_any  = |irq_req;
  assign irq_id   = irq_lvl;
  assign pc_seq   = pc_cur + NrOfBits'(4);
  assign ret_addr = br_taken ? br_target : pc_seq;
  assign halted   = (state == ST_HALTED);

`ifdef PC_IRQ_NEST_EN
  logic [NrOfBits-1:0] epc_stk [3];
  logic [1:0]          lvl_stk [3];
  logic [1:0]          depth;
  logic [1:0]          top;

  assign top        = (depth == 2'd0) ? 2'd0 : depth - 2'd1;
  assign in_service = (depth != 2'd0);
  assign epc        = epc_stk[top];
  // A new request must strictly outrank the innermost level in service.
  assign can_accept = (depth != 2'd3) && (!in_service || (irq_lvl > lvl_stk[top]));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      depth <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        epc_stk[i] <= '0;
        lvl_stk[i] <= 2'd0;
      end
    end else if (ctx_push) begin
      epc_stk[depth] <= ret_addr;
      lvl_stk[depth] <= irq_lvl;
      depth          <= depth + 2'd1;
    end else if (ctx_pop) begin
      depth <= depth - 2'd1;
    end
  end
`else
  logic [NrOfBits-1:0] epc_q;
  logic                svc_q;

  assign in_service = svc_q;
  assign epc        = epc_q;
  assign can_accept = !svc_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      epc_q <= '0;
      svc_q <= 1'b0;
    end else if (ctx_push) begin
      epc_q <= ret_addr;
      svc_q <= 1'b1;
    end else if (ctx_pop) begin
      svc_q <= 1'b0;
    end
  end
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= ST_BOOT;
    else       state <= state_nxt;
  end

  // Everything is gated by Reset so no pulse leaks out during the reset cycle.
  always_comb begin
    state_nxt = state;
    pc_next   = pc_seq;
    pc_en     = 1'b0;
    irq_ack   = 1'b0;
    mret_err  = 1'b0;
    ctx_push  = 1'b0;
    ctx_pop   = 1'b0;
    if (Tick && !Reset) begin
      case (state)
        ST_BOOT: begin
          pc_next   = ResetVector;
          pc_en     = 1'b1;
          state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (!stall) begin
            if (halt_req) begin
              state_nxt = ST_HALTED;
            end else begin
              pc_en = 1'b1;
              if (mret) begin
                if (in_service) begin
                  pc_next = epc;
                  ctx_pop = 1'b1;
                end else begin
                  mret_err = 1'b1;
                end
              end else if (irq_any && can_accept) begin
                pc_next  = IrqBase + NrOfBits'({irq_lvl, 2'b00});
                irq_ack  = 1'b1;
                ctx_push = 1'b1;
              end else if (br_taken) begin
                pc_next = br_target;
              end
            end
          end
        end
        ST_HALTED: begin
          if (resume && !halt_req) state_nxt = ST_RUN;
        end
        default: state_nxt = ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized bench for pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] IB = 32'h0000_1000;
`ifdef PC_IRQ_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic        Clock = 1'b0, Reset = 1'b0, Tick = 1'b0, stall = 1'b0;
  logic        br_taken = 1'b0, mret = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic [31:0] pc_cur = '0, br_target = '0;
  logic [2:0]  irq_req = '0;
  logic [31:0] pc_next, epc;
  logic        pc_en, irq_ack, in_service, halted, mret_err;
  logic [1:0]  irq_id;

  int checks = 0;
  int errors = 0;

  // Reference model: 0=boot 1=run 2=halted, interrupt context as a stack of (return address, level).
  int          mode = 0;
  logic [31:0] q_epc[$];
  int          q_lvl[$];

  logic [31:0] s_next;
  logic        s_en, s_ack, s_err;
  logic [1:0]  s_id;

  always #5 Clock = ~Clock;

  pc_sequencer #(.NrOfBits(32), .ResetVector(RV), .IrqBase(IB)) dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .pc_cur(pc_cur), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .irq_req(irq_req), .mret(mret),
    .halt_req(halt_req), .resume(resume), .pc_next(pc_next), .pc_en(pc_en),
    .irq_ack(irq_ack), .irq_id(irq_id), .epc(epc), .in_service(in_service),
    .halted(halted), .mret_err(mret_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    chk("rst_pc_en", 32'(pc_en), 32'd0);
    chk("rst_irq_ack", 32'(irq_ack), 32'd0);
    chk("rst_mret_err", 32'(mret_err), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_in_service", 32'(in_service), 32'd0);
    chk("rst_epc", epc, 32'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    mode  = 0;
    q_epc.delete();
    q_lvl.delete();
  endtask

  task automatic cyc(input logic t, input logic st, input logic bt, input logic [31:0] tgt,
                     input logic [2:0] irq, input logic m, input logic h, input logic r,
                     input logic [31:0] pc);
    logic [31:0] e_next, ret;
    logic        e_en, e_ack, e_err;
    int          lvl, nmode;
    bit          ok, push, pop;
    Tick = t; stall = st; br_taken = bt; br_target = tgt; irq_req = irq;
    mret = m; halt_req = h; resume = r; pc_cur = pc;
    #1;
    e_next = pc + 32'd4; e_en = 1'b0; e_ack = 1'b0; e_err = 1'b0;
    nmode = mode; push = 1'b0; pop = 1'b0;
    ret = bt ? tgt : pc + 32'd4;
    lvl = irq[2] ? 2 : irq[1] ? 1 : irq[0] ? 0 : -1;
    ok = (lvl >= 0) && ((q_epc.size() == 0) ||
         (NEST && q_epc.size() < 3 && lvl > q_lvl[q_lvl.size()-1]));
    if (t) begin
      if (mode == 0) begin
        e_next = RV; e_en = 1'b1; nmode = 1;
      end else if (mode == 1) begin
        if (!st) begin
          if (h) nmode = 2;
          else begin
            e_en = 1'b1;
            if (m) begin
              if (q_epc.size() > 0) begin e_next = q_epc[q_epc.size()-1]; pop = 1'b1; end
              else e_err = 1'b1;
            end else if (ok) begin
              e_next = IB + 32'(lvl * 4); e_ack = 1'b1; push = 1'b1;
            end else if (bt) e_next = tgt;
          end
        end
      end else if (r && !h) nmode = 1;
    end
    s_next = pc_next; s_en = pc_en; s_ack = irq_ack; s_err = mret_err; s_id = irq_id;
    chk("pc_en", 32'(pc_en), 32'(e_en));
    chk("irq_ack", 32'(irq_ack), 32'(e_ack));
    chk("mret_err", 32'(mret_err), 32'(e_err));
    if (e_en) chk("pc_next", pc_next, e_next);
    if (e_ack) chk("irq_id", 32'(irq_id), 32'(lvl));
    @(posedge Clock);
    #1;
    mode = nmode;
    if (pop) begin void'(q_epc.pop_back()); void'(q_lvl.pop_back()); end
    if (push) begin q_epc.push_back(ret); q_lvl.push_back(lvl); end
    chk("in_service", 32'(in_service), 32'(q_epc.size() > 0));
    chk("halted", 32'(halted), 32'(mode == 2));
    if (q_epc.size() > 0) chk("epc", epc, q_epc[q_epc.size()-1]);
  endtask

  initial begin
    logic [31:0] rpc;
    #2;
    do_reset();

    // Boot then sequential
    cyc(1, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0000_0123);
    chk("boot_next", s_next, 32'h0); chk("boot_en", 32'(s_en), 32'd1);
    cyc(1, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0);
    chk("seq_next", s_next, 32'h4);

    // Irq over a taken branch, then return
    cyc(1, 0, 1, 32'h200, 3'b010, 0, 0, 0, 32'h100);
    chk("irq_vec", s_next, 32'h1004); chk("irq_id1", 32'(s_id), 32'd1);
    chk("irq_ack1", 32'(s_ack), 32'd1); chk("irq_epc", epc, 32'h200);
    cyc(1, 0, 0, 0, 3'b000, 1, 0, 0, 32'h1004);
    chk("mret_next", s_next, 32'h200); chk("mret_svc", 32'(in_service), 32'd0);

    // Wraparound and stray mret
    cyc(1, 0, 0, 0, 3'b000, 0, 0, 0, 32'hFFFF_FFFC);
    chk("wrap_next", s_next, 32'h0);
    cyc(1, 0, 0, 0, 3'b000, 1, 0, 0, 32'h40);
    chk("mret_err", 32'(s_err), 32'd1); chk("mret_err_next", s_next, 32'h44);

    // Tick low holds everything
    cyc(0, 0, 1, 32'h300, 3'b111, 0, 0, 0, 32'h50);
    chk("tick0_en", 32'(s_en), 32'd0); chk("tick0_ack", 32'(s_ack), 32'd0);

    // Stall blocks acceptance; request stays pending
    repeat (3) begin
      cyc(1, 1, 0, 0, 3'b100, 0, 0, 0, 32'h60);
      chk("stall_en", 32'(s_en), 32'd0); chk("stall_ack", 32'(s_ack), 32'd0);
    end
    cyc(1, 0, 0, 0, 3'b100, 0, 0, 0, 32'h60);
    chk("unstall_ack", 32'(s_ack), 32'd1); chk("unstall_id", 32'(s_id), 32'd2);
    cyc(1, 0, 0, 0, 3'b000, 1, 0, 0, 32'h1008);

    // Halt wins over irq; resume; irq then accepted
    cyc(1, 0, 0, 0, 3'b001, 0, 1, 0, 32'h70);
    chk("halt_en", 32'(s_en), 32'd0); chk("halt_flag", 32'(halted), 32'd1);
    cyc(1, 0, 0, 0, 3'b001, 0, 0, 0, 32'h70);
    chk("halted_ack", 32'(s_ack), 32'd0);
    cyc(1, 0, 0, 0, 3'b001, 0, 1, 1, 32'h70);
    chk("halt_resume_both", 32'(halted), 32'd1);
    cyc(1, 0, 0, 0, 3'b001, 0, 0, 1, 32'h70);
    chk("resumed", 32'(halted), 32'd0);
    cyc(1, 0, 0, 0, 3'b001, 0, 0, 0, 32'h70);
    chk("post_resume_ack", 32'(s_ack), 32'd1); chk("post_resume_id", 32'(s_id), 32'd0);

    // Higher level while level 0 is in service
    cyc(1, 0, 0, 0, 3'b100, 0, 0, 0, 32'h1000);
`ifdef PC_IRQ_NEST_EN
    chk("nest_ack", 32'(s_ack), 32'd1);
    cyc(1, 0, 0, 0, 3'b000, 1, 0, 0, 32'h1010);
    chk("nest_ret1", s_next, 32'h1004);
    cyc(1, 0, 0, 0, 3'b000, 1, 0, 0, 32'h1020);
    chk("nest_ret2", s_next, 32'h74);
`else
    chk("mask_ack", 32'(s_ack), 32'd0);
    cyc(1, 0, 0, 0, 3'b100, 1, 0, 0, 32'h1004);
    chk("mask_ret", s_next, 32'h74); chk("mask_ret_ack", 32'(s_ack), 32'd0);
    cyc(1, 0, 0, 0, 3'b100, 0, 0, 0, 32'h74);
    chk("mask_late_ack", 32'(s_ack), 32'd1);
    cyc(1, 0, 0, 0, 3'b000, 1, 0, 0, 32'h1008);
`endif

    // Reset during irq entry and during halt
    cyc(1, 0, 0, 0, 3'b010, 0, 0, 0, 32'h80);
    Tick = 1'b1; irq_req = 3'b001; mret = 1'b1;
    do_reset();
    cyc(1, 0, 0, 0, 3'b000, 0, 0, 0, 32'h90);
    chk("reboot_next", s_next, 32'h0);
    cyc(1, 0, 0, 0, 3'b000, 0, 1, 0, 32'h94);
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      rpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
          $urandom() & 32'hFFFF_FFFC,
          ($urandom_range(0, 4) < 2) ? 3'($urandom_range(1, 7)) : 3'b000,
          $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
          rpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter NrOfBits, 32, width of PC and all address ports.
REQ-002 Parameter ResetVector, 32'h0000_0000, PC value loaded on first RUN cycle after reset.
REQ-003 Parameter IrqBase, 32'h0000_1000, base of interrupt vector table (4-byte entries).
REQ-004 Clock  in  1  system clock; all state changes on rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 Tick  in  1  clock qualifier; state advances only when Tick=1.
REQ-007 pc_cur  in  NrOfBits  current value of PC register.
REQ-008 stall  in  1  pipeline hold request.
REQ-009 br_taken / br_target  in  1 / NrOfBits  taken branch/jump and its target.
REQ-010 irq_req  in  3  level-sensitive interrupt requests, bit 2 highest priority.
REQ-011 mret  in  1  return-from-interrupt strobe.
REQ-012 halt_req / resume  in  1 / 1  enter/leave HALTED.
REQ-013 pc_next  out  NrOfBits  value for PC register D input.
REQ-014 pc_en  out  1  PC register ClockEnable.
REQ-015 irq_ack / irq_id  out  1 / 2  one-cycle acknowledge pulse and accepted level (0..2).
REQ-016 epc  out  NrOfBits  saved return address of innermost in-service interrupt.
REQ-017 in_service / halted / mret_err  out  1 / 1 / 1  status flags; mret_err is one-cycle pulse.

Function
REQ-018 States SHALL be BOOT, RUN, HALTED; BOOT lasts exactly one Tick cycle, drives pc_next=ResetVector, pc_en=1, then goes to RUN.
REQ-019 Cycles with Tick=0 SHALL hold all state, force pc_en=0 and suppress all pulses.
REQ-020 In RUN with stall=0, source priority SHALL be: mret > accepted irq > br_taken > sequential (pc_cur+4), pc_en=1.
REQ-021 stall=1 SHALL force pc_en=0 and block irq acceptance, mret and halt entry; requests stay pending (irq level) or are lost (pulses, caller's responsibility).
REQ-022 Irq accepted when any enabled irq_req bit set and not masked: pc_next=IrqBase+(irq_id<<2), irq_ack=1, epc:=address that would otherwise have been loaded (br_target if br_taken else pc_cur+4), in_service:=1.
REQ-023 mret with in_service=1 SHALL load pc_next=epc and clear in_service (or pop, see REQ-031); mret with in_service=0 SHALL act as sequential and pulse mret_err.
REQ-024 pc_cur+4 and vector arithmetic SHALL wrap modulo 2^NrOfBits.
REQ-025 halt_req in RUN (stall=0) SHALL win over irq/branch in the same cycle: pc_en=0, next state HALTED; irq stays pending.
REQ-026 HALTED: pc_en=0, halted=1, irqs not accepted; resume SHALL return to RUN next cycle; halt_req and resume together keep HALTED.
REQ-027 Same-cycle mret and irq: mret executes, irq re-evaluated next cycle.

Reset
REQ-028 Reset SHALL asynchronously force state BOOT, epc=0, in_service=0, pc_en=0, irq_ack=0, mret_err=0, halted=0, nesting depth 0.
REQ-029 Reset asserted mid-interrupt-entry or mid-halt SHALL discard all pending context; no pulse is emitted in the reset cycle.

Configuration
REQ-030 Macro PC_IRQ_NEST_EN SHALL control nested interrupts.
REQ-031 Defined: 3-entry epc/level stack; irq accepted while in_service only if its level exceeds current level; mret pops; depth-3 overflow blocks acceptance; in_service=depth>0.
REQ-032 Undefined: single epc register; all irqs masked while in_service=1.

Verification
REQ-033 Reset release, Tick=1 -> cycle 1 pc_next=0 pc_en=1; cycle 2 pc_next=pc_cur+4.
REQ-034 pc_cur=0x100, br_taken=1 target 0x200, irq_req=3'b010 -> pc_next=0x1004, irq_id=1, irq_ack pulse, epc=0x200; then mret -> pc_next=0x200, in_service=0.
REQ-035 pc_cur=0xFFFF_FFFC sequential -> pc_next=0x0; mret with in_service=0 -> mret_err pulse, pc_next=pc_cur+4.
REQ-036 stall=1 with irq_req=3'b100 for 3 cycles -> pc_en=0, no ack; stall drop -> ack with irq_id=2 next Tick.
REQ-037 halt_req with irq_req=1 -> HALTED, pc_en=0; resume -> RUN, irq accepted next cycle.
REQ-038 With PC_IRQ_NEST_EN: level 0 in service, irq_req=3'b100 -> nested ack, two mret return in order; without macro -> level 2 not acked until mret.
